// File: rtl/multicycle_control.sv
// Control FSM for the multicycle CPU datapath: walks each instruction through its states,
// drives every datapath control line and counts retired instructions.
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IReg_out,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        ALUSrcA,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        BranchType,
    output logic [1:0]  PCSource,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  ALUOp,
    output logic        halted,
    output logic [3:0]  state,
    output logic [31:0] instr_retired
);

    localparam logic [3:0] ALU_ADD = 4'b0000;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC   = 4'd2,
        WB     = 4'd3,
        MEM_RD = 4'd4,
        MEM_WB = 4'd5,
        MEM_WR = 4'd6,
        BRANCH = 4'd7,
        JUMP   = 4'd8,
        HALT   = 4'd9,
        NEXT   = 4'd10
    } state_t;

    typedef enum logic [3:0] {
        CL_R, CL_ISE, CL_IZE, CL_LW, CL_SW, CL_J, CL_BEQ, CL_BNE, CL_HALT, CL_NOP
    } class_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic       branch_type;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
    } ctrl_t;

    state_t      cur_state;
    logic [5:0]  op_reg;
    ctrl_t       ctrl_q;
    logic [31:0] retired_q;
    logic        unused_operand_bits;

    function automatic class_t classify(input logic [5:0] opc);
        class_t cl;
        cl = CL_NOP;
        if (opc[5:4] == 2'b00) begin
            cl = CL_R;
        end else if (opc[5:3] == 3'b010) begin
            cl = CL_ISE;
        end else if (opc[5:3] == 3'b011) begin
            cl = CL_IZE;
        end else begin
            case (opc)
                6'b100000: cl = CL_LW;
                6'b100001: cl = CL_SW;
                6'b110000: cl = CL_J;
                6'b110001: cl = CL_BEQ;
                6'b110010: cl = CL_BNE;
                6'b111111: cl = CL_HALT;
                default:   cl = CL_NOP;
            endcase
        end
        return cl;
    endfunction

    function automatic state_t next_state(input state_t cur, input logic [5:0] opc);
        state_t nxt;
        nxt = FETCH;
        case (cur)
            FETCH:  nxt = DECODE;
            DECODE: begin
                case (classify(opc))
                    CL_R, CL_ISE, CL_IZE: nxt = EXEC;
                    CL_LW:                nxt = MEM_RD;
                    CL_SW:                nxt = MEM_WR;
                    CL_BEQ, CL_BNE:       nxt = BRANCH;
                    CL_J:                 nxt = JUMP;
                    CL_HALT:              nxt = HALT;
                    default:              nxt = NEXT;
                endcase
            end
            EXEC:   nxt = WB;
            MEM_RD: nxt = MEM_WB;
            HALT:   nxt = HALT;
            default: nxt = FETCH;
        endcase
        return nxt;
    endfunction

    function automatic logic is_final(input state_t s);
        return (s == WB) || (s == MEM_WB) || (s == MEM_WR) ||
               (s == BRANCH) || (s == JUMP) || (s == NEXT);
    endfunction

    function automatic ctrl_t pc_increment();
        ctrl_t c;
        c           = '0;
        c.pc_write  = 1'b1;
        c.pc_source = 2'b00;
        c.alu_src_a = 1'b0;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALU_ADD;
        return c;
    endfunction

    // The PC is only touched in final states because the IR reloads every cycle.
    function automatic ctrl_t controls(input state_t s, input logic [5:0] opc);
        ctrl_t c;
        c = '0;
        case (s)
            EXEC: begin
                c.alu_src_a = 1'b1;
                case (classify(opc))
                    CL_R:   begin c.alu_src_b = 2'b00; c.alu_op = opc[3:0];         end
                    CL_ISE: begin c.alu_src_b = 2'b10; c.alu_op = {1'b0, opc[2:0]}; end
                    CL_IZE: begin c.alu_src_b = 2'b11; c.alu_op = {1'b0, opc[2:0]}; end
                    default: c.alu_src_b = 2'b00;
                endcase
            end
            WB: begin
                c           = pc_increment();
                c.reg_write = 1'b1;
            end
            MEM_RD: c.mem_read = 1'b1;
            MEM_WB: begin
                c            = pc_increment();
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                c           = pc_increment();
                c.mem_write = 1'b1;
            end
            NEXT: c = pc_increment();
            BRANCH: begin
                c               = pc_increment();
                c.pc_write_cond = 1'b1;
                c.branch_type   = (classify(opc) == CL_BNE);
            end
            JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Outputs are registered alongside the state so they always reflect the state being entered;
    // the opcode seen during DECODE is the one latched for the rest of the instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= FETCH;
            op_reg    <= '0;
            retired_q <= '0;
            ctrl_q    <= '0;
        end else begin
            cur_state <= next_state(cur_state, IReg_out[31:26]);
            if (cur_state == DECODE) begin
                op_reg <= IReg_out[31:26];
            end
            if (is_final(cur_state)) begin
                retired_q <= retired_q + 32'd1;
            end
            ctrl_q <= controls(next_state(cur_state, IReg_out[31:26]),
                               (cur_state == DECODE) ? IReg_out[31:26] : op_reg);
        end
    end

    assign unused_operand_bits = ^IReg_out[25:0];

    assign PCWrite       = ctrl_q.pc_write;
    assign PCWriteCond   = ctrl_q.pc_write_cond;
    assign IorD          = 1'b0;
    assign MemRead       = ctrl_q.mem_read;
    assign MemWrite      = ctrl_q.mem_write;
    assign IRWrite       = 1'b0;
    assign MemtoReg      = ctrl_q.mem_to_reg;
    assign ALUSrcA       = ctrl_q.alu_src_a;
    assign RegWrite      = ctrl_q.reg_write;
    assign RegDst        = 1'b0;
    assign BranchType    = ctrl_q.branch_type;
    assign PCSource      = ctrl_q.pc_source;
    assign ALUSrcB       = ctrl_q.alu_src_b;
    assign ALUOp         = ctrl_q.alu_op;
    assign halted        = (cur_state == HALT);
    assign state         = cur_state;
    assign instr_retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected state, controls and counter
// are queued for each instruction, then compared on the falling clock edge.
module tb_multicycle_control;

    logic        clk;
    logic        reset;
    logic [31:0] IReg_out;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, ALUSrcA, RegWrite, RegDst, BranchType;
    logic [1:0]  PCSource, ALUSrcB;
    logic [3:0]  ALUOp;
    logic        halted;
    logic [3:0]  state;
    logic [31:0] instr_retired;

    multicycle_control dut (
        .clk(clk), .reset(reset), .IReg_out(IReg_out),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .BranchType(BranchType), .PCSource(PCSource),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .halted(halted),
        .state(state), .instr_retired(instr_retired)
    );

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  st;
        logic [18:0] ctl;
        logic [31:0] cnt;
        logic        halt;
    } exp_t;

    exp_t        sb[$];
    logic [18:0] ctl_obs;
    logic [31:0] exp_retired;
    int          checks;
    int          passed;

    assign ctl_obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                      ALUSrcA, RegWrite, RegDst, BranchType, PCSource, ALUSrcB, ALUOp};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [18:0] ctl(input logic pcw, input logic pcwc, input logic memr,
                                        input logic memw, input logic m2r, input logic srca,
                                        input logic regw, input logic bt, input logic [1:0] pcs,
                                        input logic [1:0] srcb, input logic [3:0] op);
        return {pcw, pcwc, 1'b0, memr, memw, 1'b0, m2r, srca, regw, 1'b0, bt, pcs, srcb, op};
    endfunction

    task automatic push(input logic [31:0] instr, input logic [3:0] st, input logic [18:0] c);
        exp_t r;
        r.instr = instr;
        r.st    = st;
        r.ctl   = c;
        r.cnt   = exp_retired;
        r.halt  = (st == 4'd9);
        sb.push_back(r);
    endtask

    // Later cycles drive an inverted word so the latched opcode is what must be decoded.
    task automatic push_alu(input logic [31:0] instr, input logic [1:0] srcb, input logic [3:0] op);
        push(instr, 4'd0, '0);
        push(instr, 4'd1, '0);
        push(~instr, 4'd2, ctl(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, srcb, op));
        push(~instr, 4'd3, ctl(1, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 4'b0000));
        exp_retired = exp_retired + 32'd1;
    endtask

    task automatic push_lw(input logic [31:0] instr);
        push(instr, 4'd0, '0);
        push(instr, 4'd1, '0);
        push(~instr, 4'd4, ctl(0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000));
        push(~instr, 4'd5, ctl(1, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b01, 4'b0000));
        exp_retired = exp_retired + 32'd1;
    endtask

    task automatic push_short(input logic [31:0] instr, input logic [3:0] st, input logic [18:0] c);
        push(instr, 4'd0, '0);
        push(instr, 4'd1, '0);
        push(~instr, st, c);
        exp_retired = exp_retired + 32'd1;
    endtask

    task automatic push_sw(input logic [31:0] instr);
        push_short(instr, 4'd6, ctl(1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 4'b0000));
    endtask

    task automatic push_branch(input logic [31:0] instr, input logic bt);
        push_short(instr, 4'd7, ctl(1, 1, 0, 0, 0, 0, 0, bt, 2'b00, 2'b01, 4'b0000));
    endtask

    task automatic push_jump(input logic [31:0] instr);
        push_short(instr, 4'd8, ctl(1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 4'b0000));
    endtask

    task automatic push_nop(input logic [31:0] instr);
        push_short(instr, 4'd10, ctl(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 4'b0000));
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        IReg_out = 32'hFC00_0000;
        repeat (3) @(negedge clk);
        checks++;
        if ({state, ctl_obs} !== {4'd0, 19'd0}) begin
            $display("[TB] FAIL reset_state: state/ctl got %0d/%05h want 0/00000", state, ctl_obs);
        end else passed++;
        checks++;
        if ({instr_retired, halted} !== {32'd0, 1'b0}) begin
            $display("[TB] FAIL reset_count: retired/halted got %0d/%0b want 0/0", instr_retired, halted);
        end else passed++;
        reset       = 1'b0;
        exp_retired = 32'd0;
    endtask

    task automatic test_alu();
        exp_t r;
        int   cyc;
        push_alu({6'b000010, 5'd1, 5'd2, 5'd3, 11'd0}, 2'b00, 4'b0010);
        push_alu({6'b001111, 26'h0ABCDE}, 2'b00, 4'b1111);
        push_alu({6'b010101, 26'h0001234}, 2'b10, 4'b0101);
        push_alu({6'b011110, 26'h000FFFF}, 2'b11, 4'b0110);
        cyc = 0;
        while (sb.size() > 0) begin
            r = sb.pop_front();
            IReg_out = r.instr;
            checks++;
            if ({state, ctl_obs} !== {r.st, r.ctl}) begin
                $display("[TB] FAIL alu c%0d: state/ctl got %0d/%05h want %0d/%05h", cyc, state, ctl_obs, r.st, r.ctl);
            end else passed++;
            checks++;
            if ({instr_retired, halted} !== {r.cnt, r.halt}) begin
                $display("[TB] FAIL alu_count c%0d: retired/halted got %0d/%0b want %0d/%0b", cyc, instr_retired, halted, r.cnt, r.halt);
            end else passed++;
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_memory();
        exp_t r;
        int   cyc;
        push_lw({6'b100000, 5'd1, 5'd0, 16'd16});
        push_sw({6'b100001, 5'd0, 5'd2, 16'd4});
        cyc = 0;
        while (sb.size() > 0) begin
            r = sb.pop_front();
            IReg_out = r.instr;
            checks++;
            if ({state, ctl_obs} !== {r.st, r.ctl}) begin
                $display("[TB] FAIL mem c%0d: state/ctl got %0d/%05h want %0d/%05h", cyc, state, ctl_obs, r.st, r.ctl);
            end else passed++;
            checks++;
            if ({instr_retired, halted} !== {r.cnt, r.halt}) begin
                $display("[TB] FAIL mem_count c%0d: retired/halted got %0d/%0b want %0d/%0b", cyc, instr_retired, halted, r.cnt, r.halt);
            end else passed++;
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_flow();
        exp_t r;
        int   cyc;
        push_branch({6'b110001, 5'd3, 5'd3, 16'd20}, 1'b0);
        push_branch({6'b110010, 5'd3, 5'd3, 16'd20}, 1'b1);
        push_jump({6'b110000, 26'h40});
        push_nop({6'b100010, 26'h0});
        push_nop({6'b101111, 26'h1});
        push_nop({6'b110011, 26'h2});
        cyc = 0;
        while (sb.size() > 0) begin
            r = sb.pop_front();
            IReg_out = r.instr;
            checks++;
            if ({state, ctl_obs} !== {r.st, r.ctl}) begin
                $display("[TB] FAIL flow c%0d: state/ctl got %0d/%05h want %0d/%05h", cyc, state, ctl_obs, r.st, r.ctl);
            end else passed++;
            checks++;
            if ({instr_retired, halted} !== {r.cnt, r.halt}) begin
                $display("[TB] FAIL flow_count c%0d: retired/halted got %0d/%0b want %0d/%0b", cyc, instr_retired, halted, r.cnt, r.halt);
            end else passed++;
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        exp_t r;
        int   n;
        push(32'h0822_1800, 4'd0, '0);
        push(32'h0822_1800, 4'd1, '0);
        push(32'h0822_1800, 4'd2, ctl(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 4'b0010));
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            r = sb.pop_front();
            IReg_out = r.instr;
            checks++;
            if ({state, ctl_obs, instr_retired} !== {r.st, r.ctl, r.cnt}) begin
                $display("[TB] FAIL rmid c%0d: state/ctl/cnt got %0d/%05h/%0d want %0d/%05h/%0d", i, state, ctl_obs, instr_retired, r.st, r.ctl, r.cnt);
            end else passed++;
            if (i == n - 1) reset = 1'b1;
            @(negedge clk);
        end
        reset       = 1'b0;
        exp_retired = 32'd0;
        checks++;
        if ({state, ctl_obs, instr_retired, halted} !== {4'd0, 19'd0, 32'd0, 1'b0}) begin
            $display("[TB] FAIL rmid_abort: state/ctl/cnt got %0d/%05h/%0d want 0/00000/0", state, ctl_obs, instr_retired);
        end else passed++;
    endtask

    task automatic test_back_to_back();
        exp_t r;
        int   cyc;
        push_sw({6'b100001, 26'h5});
        push_alu({6'b000000, 26'h3}, 2'b00, 4'b0000);
        push_jump({6'b110000, 26'h3FFFFFF});
        push_lw({6'b100000, 26'h7});
        push_branch({6'b110010, 26'h9}, 1'b1);
        push_alu({6'b010000, 26'h1}, 2'b10, 4'b0000);
        cyc = 0;
        while (sb.size() > 0) begin
            r = sb.pop_front();
            IReg_out = r.instr;
            checks++;
            if ({state, ctl_obs} !== {r.st, r.ctl}) begin
                $display("[TB] FAIL b2b c%0d: state/ctl got %0d/%05h want %0d/%05h", cyc, state, ctl_obs, r.st, r.ctl);
            end else passed++;
            checks++;
            if ({instr_retired, halted} !== {r.cnt, r.halt}) begin
                $display("[TB] FAIL b2b_count c%0d: retired/halted got %0d/%0b want %0d/%0b", cyc, instr_retired, halted, r.cnt, r.halt);
            end else passed++;
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_halt();
        exp_t r;
        int   cyc;
        push(32'hFC00_0000, 4'd0, '0);
        push(32'hFC00_0000, 4'd1, '0);
        for (int i = 0; i < 12; i++) push(32'h0822_1800, 4'd9, '0);
        cyc = 0;
        while (sb.size() > 0) begin
            r = sb.pop_front();
            IReg_out = r.instr;
            checks++;
            if ({state, ctl_obs} !== {r.st, r.ctl}) begin
                $display("[TB] FAIL halt c%0d: state/ctl got %0d/%05h want %0d/%05h", cyc, state, ctl_obs, r.st, r.ctl);
            end else passed++;
            checks++;
            if ({instr_retired, halted} !== {r.cnt, r.halt}) begin
                $display("[TB] FAIL halt_count c%0d: retired/halted got %0d/%0b want %0d/%0b", cyc, instr_retired, halted, r.cnt, r.halt);
            end else passed++;
            cyc++;
            if (sb.size() == 0) reset = 1'b1;
            @(negedge clk);
        end
        reset = 1'b0;
        checks++;
        if ({state, ctl_obs, instr_retired, halted} !== {4'd0, 19'd0, 32'd0, 1'b0}) begin
            $display("[TB] FAIL halt_exit: state/ctl/cnt/halted got %0d/%05h/%0d/%0b want 0/00000/0/0", state, ctl_obs, instr_retired, halted);
        end else passed++;
    endtask

    initial begin
        checks      = 0;
        passed      = 0;
        exp_retired = 32'd0;
        reset       = 1'b1;
        IReg_out    = 32'd0;
        test_reset();
        test_alu();
        test_memory();
        test_flow();
        test_reset_mid();
        test_back_to_back();
        test_halt();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
